tag_reorder_fifo: RTL and testbench

- Reorder buffer for split-transaction links. Slot IDs are allocated in order as requests issue.
- Responses are written back by ID in any order. Data is dequeued strictly in allocation order.
- Used by network bridges, e.g. the MMIO bridge, to return loads and store-acks in issue order. Write data can be a dummy value when the entry only marks completion.

---
 rtl/tag_reorder_fifo_pkg.sv | 12 +
 rtl/tag_reorder_fifo_mem.sv | 28 ++
 rtl/tag_reorder_fifo.sv | 127 ++++++++++++
 tb/tb_tag_reorder_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tag_reorder_fifo_pkg.sv
// Shared helpers for the tag reorder FIFO: default sizing and a clog2 that never returns zero.
package tag_reorder_fifo_pkg;

    localparam int default_width_lp = 32;
    localparam int default_els_lp   = 4;

    // A single-entry range still needs a one-bit field.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tag_reorder_fifo_mem.sv
// Entry storage for the tag reorder FIFO: one synchronous write port and one asynchronous read port, not reset.
module tag_reorder_fifo_mem
    import tag_reorder_fifo_pkg::*;
#(
    parameter int width_p      = default_width_lp,
    parameter int els_p        = default_els_lp,
    parameter int addr_width_p = safe_clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    w_v_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic [addr_width_p-1:0] r_addr_i,
    output logic [width_p-1:0]      r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // Addresses beyond els_p only exist when els_p is not a power of two; drop them.
    always_ff @(posedge clk_i) begin
        if (w_v_i && (int'(w_addr_i) < els_p)) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/tag_reorder_fifo.sv
// Reorder buffer: IDs are allocated in order, completed by ID in any order, dequeued in allocation order.
// Optional simulation-only protocol checks are enabled by defining TAG_REORDER_FIFO_CHECKS_EN.
module tag_reorder_fifo
    import tag_reorder_fifo_pkg::*;
#(
    parameter int  width_p     = default_width_lp,
    parameter int  els_p       = default_els_lp,
    localparam int id_width_lp = safe_clog2(els_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    output logic [id_width_lp-1:0] fifo_alloc_id_o,
    output logic                   fifo_alloc_v_o,
    input  logic                   fifo_alloc_yumi_i,
    input  logic [id_width_lp-1:0] write_id_i,
    input  logic [width_p-1:0]     write_data_i,
    input  logic                   write_v_i,
    output logic [width_p-1:0]     fifo_deq_data_o,
    output logic                   fifo_deq_v_o,
    input  logic                   fifo_deq_yumi_i,
    output logic                   empty_o
);

    localparam int cnt_width_lp = safe_clog2(els_p + 1);
    localparam logic [id_width_lp-1:0]  last_id_lp  = id_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

    logic [id_width_lp-1:0]  wptr_q, wptr_d;
    logic [id_width_lp-1:0]  rptr_q, rptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic [els_p-1:0]        valid_q, valid_d;
    logic                    alloc_fire, deq_fire;

    assign fifo_alloc_v_o  = (count_q != full_cnt_lp);
    assign fifo_alloc_id_o = wptr_q;
    assign fifo_deq_v_o    = valid_q[rptr_q] & (count_q != '0);
    assign empty_o         = (count_q == '0);

    // Handshakes are qualified so a stray yumi can never corrupt the pointers.
    assign alloc_fire = fifo_alloc_yumi_i & fifo_alloc_v_o;
    assign deq_fire   = fifo_deq_yumi_i & fifo_deq_v_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        valid_d = valid_q;

        if (alloc_fire) begin
            wptr_d = (wptr_q == last_id_lp) ? '0 : wptr_q + id_width_lp'(1);
        end
        if (deq_fire) begin
            rptr_d = (rptr_q == last_id_lp) ? '0 : rptr_q + id_width_lp'(1);
        end

        unique case ({alloc_fire, deq_fire})
            2'b10:   count_d = count_q + cnt_width_lp'(1);
            2'b01:   count_d = count_q - cnt_width_lp'(1);
            default: count_d = count_q;
        endcase

        if (write_v_i) begin
            valid_d[write_id_i] = 1'b1;
        end
        if (deq_fire) begin
            valid_d[rptr_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    tag_reorder_fifo_mem #(
        .width_p     (width_p),
        .els_p       (els_p),
        .addr_width_p(id_width_lp)
    ) mem (
        .clk_i   (clk_i),
        .w_v_i   (write_v_i),
        .w_addr_i(write_id_i),
        .w_data_i(write_data_i),
        .r_addr_i(rptr_q),
        .r_data_o(fifo_deq_data_o)
    );

`ifdef TAG_REORDER_FIFO_CHECKS_EN
    // An ID is outstanding when its distance from the head is inside the occupied window.
    function automatic logic id_allocated(input logic [id_width_lp-1:0] id);
        int off;
        if (int'(id) >= els_p) begin
            return 1'b0;
        end
        off = (int'(id) - int'(rptr_q) + els_p) % els_p;
        return (off < int'(count_q));
    endfunction

    always @(posedge clk_i) begin
        if (!reset_i) begin
            if (fifo_alloc_yumi_i && !fifo_alloc_v_o) begin
                $error("tag_reorder_fifo: alloc yumi while full, id %0d", wptr_q);
            end
            if (fifo_deq_yumi_i && !fifo_deq_v_o) begin
                $error("tag_reorder_fifo: deq yumi while head not valid, id %0d", rptr_q);
            end
            if (write_v_i && !id_allocated(write_id_i)) begin
                $error("tag_reorder_fifo: write to unallocated id %0d", write_id_i);
            end
            if (write_v_i && id_allocated(write_id_i) && valid_q[write_id_i]) begin
                $error("tag_reorder_fifo: write to already valid id %0d", write_id_i);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_tag_reorder_fifo.sv
// Directed self-checking bench for tag_reorder_fifo with a 4-entry and a 3-entry instance.
module tb_tag_reorder_fifo;

    logic        clk;
    int          checks_total;
    int          checks_passed;

    logic        a_rst, a_alloc_v, a_alloc_yumi, a_write_v, a_deq_v, a_deq_yumi, a_empty;
    logic [1:0]  a_alloc_id, a_write_id;
    logic [31:0] a_write_data, a_deq_data;

    logic        b_rst, b_alloc_v, b_alloc_yumi, b_write_v, b_deq_v, b_deq_yumi, b_empty;
    logic [1:0]  b_alloc_id, b_write_id;
    logic [31:0] b_write_data, b_deq_data;

    tag_reorder_fifo #(.width_p(32), .els_p(4)) dut4 (
        .clk_i            (clk),
        .reset_i          (a_rst),
        .fifo_alloc_id_o  (a_alloc_id),
        .fifo_alloc_v_o   (a_alloc_v),
        .fifo_alloc_yumi_i(a_alloc_yumi),
        .write_id_i       (a_write_id),
        .write_data_i     (a_write_data),
        .write_v_i        (a_write_v),
        .fifo_deq_data_o  (a_deq_data),
        .fifo_deq_v_o     (a_deq_v),
        .fifo_deq_yumi_i  (a_deq_yumi),
        .empty_o          (a_empty)
    );

    tag_reorder_fifo #(.width_p(32), .els_p(3)) dut3 (
        .clk_i            (clk),
        .reset_i          (b_rst),
        .fifo_alloc_id_o  (b_alloc_id),
        .fifo_alloc_v_o   (b_alloc_v),
        .fifo_alloc_yumi_i(b_alloc_yumi),
        .write_id_i       (b_write_id),
        .write_data_i     (b_write_data),
        .write_v_i        (b_write_v),
        .fifo_deq_data_o  (b_deq_data),
        .fifo_deq_v_o     (b_deq_v),
        .fifo_deq_yumi_i  (b_deq_yumi),
        .empty_o          (b_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, land 1ns after the edge, and drop all one-shot strobes.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        a_alloc_yumi = 1'b0;
        a_write_v    = 1'b0;
        a_deq_yumi   = 1'b0;
        b_alloc_yumi = 1'b0;
        b_write_v    = 1'b0;
        b_deq_yumi   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        a_rst = 1'b1; a_alloc_yumi = 1'b0; a_write_v = 1'b0; a_deq_yumi = 1'b0;
        a_write_id = '0; a_write_data = '0;
        b_rst = 1'b1; b_alloc_yumi = 1'b0; b_write_v = 1'b0; b_deq_yumi = 1'b0;
        b_write_id = '0; b_write_data = '0;
        applyStimulus();
        applyStimulus();
        a_rst = 1'b0;
        b_rst = 1'b0;
        applyStimulus();

        $display("[TB] reset and idle");
        checkOutput("rst_alloc_v", 32'(a_alloc_v), 32'd1);
        checkOutput("rst_alloc_id", 32'(a_alloc_id), 32'd0);
        checkOutput("rst_deq_v", 32'(a_deq_v), 32'd0);
        checkOutput("rst_empty", 32'(a_empty), 32'd1);

        $display("[TB] out-of-order completion, els_p=4");
        for (int k = 0; k < 3; k++) begin
            checkOutput("ooo_alloc_id", 32'(a_alloc_id), 32'(k));
            a_alloc_yumi = 1'b1;
            applyStimulus();
        end
        checkOutput("ooo_empty_low", 32'(a_empty), 32'd0);
        checkOutput("ooo_deq_v_none", 32'(a_deq_v), 32'd0);
        a_write_v = 1'b1; a_write_id = 2'd2; a_write_data = 32'hC;
        applyStimulus();
        checkOutput("ooo_deq_v_after_id2", 32'(a_deq_v), 32'd0);
        a_write_v = 1'b1; a_write_id = 2'd0; a_write_data = 32'hA;
        #1;
        checkOutput("ooo_no_bypass", 32'(a_deq_v), 32'd0);
        applyStimulus();
        checkOutput("ooo_deq_v_id0", 32'(a_deq_v), 32'd1);
        checkOutput("ooo_data_a", a_deq_data, 32'hA);
        a_write_v = 1'b1; a_write_id = 2'd1; a_write_data = 32'hB;
        a_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("ooo_deq_v_id1", 32'(a_deq_v), 32'd1);
        checkOutput("ooo_data_b", a_deq_data, 32'hB);
        a_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("ooo_data_c", a_deq_data, 32'hC);
        a_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("ooo_empty_after", 32'(a_empty), 32'd1);
        checkOutput("ooo_deq_v_after", 32'(a_deq_v), 32'd0);
        checkOutput("ooo_alloc_id_after", 32'(a_alloc_id), 32'd3);

        $display("[TB] full behaviour");
        a_rst = 1'b1;
        applyStimulus();
        a_rst = 1'b0;
        applyStimulus();
        checkOutput("full_reset_id", 32'(a_alloc_id), 32'd0);
        for (int k = 0; k < 4; k++) begin
            a_alloc_yumi = 1'b1;
            applyStimulus();
        end
        checkOutput("full_alloc_v", 32'(a_alloc_v), 32'd0);
        a_write_v = 1'b1; a_write_id = 2'd0; a_write_data = 32'h5;
        applyStimulus();
        checkOutput("full_deq_v", 32'(a_deq_v), 32'd1);
        checkOutput("full_deq_data", a_deq_data, 32'h5);
        a_deq_yumi = 1'b1;
        #1;
        checkOutput("full_alloc_v_during_deq", 32'(a_alloc_v), 32'd0);
        applyStimulus();
        checkOutput("full_alloc_v_next", 32'(a_alloc_v), 32'd1);
        checkOutput("full_alloc_id_next", 32'(a_alloc_id), 32'd0);

        $display("[TB] streaming alloc+dequeue with wrap");
        a_write_v = 1'b1; a_write_id = 2'd1; a_write_data = 32'h100;
        applyStimulus();
        a_write_v = 1'b1; a_write_id = 2'd2; a_write_data = 32'h101;
        applyStimulus();
        for (int i = 0; i < 10; i++) begin
            checkOutput("stream_deq_v", 32'(a_deq_v), 32'd1);
            checkOutput("stream_data", a_deq_data, 32'h100 + 32'(i));
            checkOutput("stream_alloc_v", 32'(a_alloc_v), 32'd1);
            checkOutput("stream_alloc_id", 32'(a_alloc_id), 32'(i % 4));
            a_deq_yumi   = 1'b1;
            a_alloc_yumi = 1'b1;
            a_write_v    = 1'b1;
            a_write_id   = 2'((3 + i) % 4);
            a_write_data = 32'h102 + 32'(i);
            applyStimulus();
        end
        checkOutput("stream_tail_data", a_deq_data, 32'h10A);

        $display("[TB] reset mid-operation");
        a_rst = 1'b1;
        #2;
        checkOutput("midrst_empty", 32'(a_empty), 32'd1);
        checkOutput("midrst_deq_v", 32'(a_deq_v), 32'd0);
        checkOutput("midrst_alloc_id", 32'(a_alloc_id), 32'd0);
        checkOutput("midrst_alloc_v", 32'(a_alloc_v), 32'd1);
        applyStimulus();
        a_rst = 1'b0;
        applyStimulus();
        checkOutput("midrst_empty_after", 32'(a_empty), 32'd1);

        $display("[TB] els_p=3 wrap-around");
        for (int k = 0; k < 3; k++) begin
            checkOutput("np2_alloc_id", 32'(b_alloc_id), 32'(k));
            b_alloc_yumi = 1'b1;
            applyStimulus();
        end
        checkOutput("np2_full", 32'(b_alloc_v), 32'd0);
        b_write_v = 1'b1; b_write_id = 2'd1; b_write_data = 32'h21;
        applyStimulus();
        b_write_v = 1'b1; b_write_id = 2'd2; b_write_data = 32'h22;
        applyStimulus();
        checkOutput("np2_head_pending", 32'(b_deq_v), 32'd0);
        b_write_v = 1'b1; b_write_id = 2'd0; b_write_data = 32'h20;
        applyStimulus();
        checkOutput("np2_deq_v", 32'(b_deq_v), 32'd1);
        checkOutput("np2_data_20", b_deq_data, 32'h20);
        b_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("np2_data_21", b_deq_data, 32'h21);
        checkOutput("np2_alloc_v", 32'(b_alloc_v), 32'd1);
        checkOutput("np2_alloc_id4", 32'(b_alloc_id), 32'd0);
        b_alloc_yumi = 1'b1; b_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("np2_data_22", b_deq_data, 32'h22);
        checkOutput("np2_alloc_id5", 32'(b_alloc_id), 32'd1);
        b_alloc_yumi = 1'b1;
        applyStimulus();
        checkOutput("np2_full2", 32'(b_alloc_v), 32'd0);
        checkOutput("np2_alloc_id_wrap", 32'(b_alloc_id), 32'd2);
        b_write_v = 1'b1; b_write_id = 2'd1; b_write_data = 32'h25;
        applyStimulus();
        checkOutput("np2_head_hold", b_deq_data, 32'h22);
        b_write_v = 1'b1; b_write_id = 2'd0; b_write_data = 32'h24;
        b_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("np2_data_24", b_deq_data, 32'h24);
        checkOutput("np2_alloc_id6", 32'(b_alloc_id), 32'd2);
        b_alloc_yumi = 1'b1; b_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("np2_data_25", b_deq_data, 32'h25);
        checkOutput("np2_alloc_id7", 32'(b_alloc_id), 32'd0);
        b_alloc_yumi = 1'b1;
        applyStimulus();
        checkOutput("np2_full3", 32'(b_alloc_v), 32'd0);
        b_write_v = 1'b1; b_write_id = 2'd0; b_write_data = 32'h27;
        b_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("np2_head2_pending", 32'(b_deq_v), 32'd0);
        b_write_v = 1'b1; b_write_id = 2'd2; b_write_data = 32'h26;
        applyStimulus();
        checkOutput("np2_data_26", b_deq_data, 32'h26);
        b_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("np2_data_27", b_deq_data, 32'h27);
        b_deq_yumi = 1'b1;
        applyStimulus();
        checkOutput("np2_empty", 32'(b_empty), 32'd1);
        checkOutput("np2_final_id", 32'(b_alloc_id), 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
